arbiter42_ctrl: RTL and testbench

//  Four-requester arbiter/sequencer for one shared resource (bus, ALU port, display driver).

---
 rtl/arbiter42_ctrl_pkg.sv | 28 ++
 rtl/arb_pick4.sv | 50 +++++
 rtl/encoder42.sv | 26 ++
 rtl/arbiter42_ctrl.sv | 109 ++++++++++
 tb/tb_arbiter42_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter42_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter42_ctrl_pkg
//  Description : Shared constants and helper for the four-requester arbiter.
//                Provides the state encodings, the requester count and a
//                one-hot to binary index helper.
//  Revision    : 1.0  initial release
// ============================================================================
package arbiter42_ctrl_pkg;

    localparam int REQ_N = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Index of the set bit of a one-hot (or zero) 4-bit vector.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < REQ_N; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage : arbiter42_ctrl_pkg
`default_nettype wire

// File: rtl/arb_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick4
//  Description : Combinational winner selection for four requesters.
//                Rotates the request vector so the search starts at
//                (last-1) mod 4, picks the highest set bit, rotates back.
//                With rr_en=0 the rotation is zero, giving fixed priority
//                3 > 2 > 1 > 0.
//  Ports       : req[3:0], last[1:0], rr_en -> win_onehot[3:0], win_any
//  Revision    : 1.0  initial release
// ============================================================================
module arb_pick4
    import arbiter42_ctrl_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       rr_en,
    output logic [3:0] win_onehot,
    output logic       win_any
);

    logic [1:0] w_base;
    logic [3:0] w_rot;
    logic [1:0] w_sel;
    logic       w_found;

    // w_rot[j] = req[(base + j) mod 4]; the top bit then holds req[base-1],
    // so scanning from bit 3 down walks last-1, last-2, last-3, last.
    always_comb begin
        w_base     = rr_en ? last : 2'd0;
        w_rot      = '0;
        w_sel      = 2'd0;
        w_found    = 1'b0;
        win_onehot = '0;
        for (int j = 0; j < REQ_N; j++) begin
            w_rot[j] = req[2'(w_base + 2'(j))];
        end
        for (int j = REQ_N - 1; j >= 0; j--) begin
            if (w_rot[j] && !w_found) begin
                w_found = 1'b1;
                w_sel   = 2'(j);
            end
        end
        if (w_found) win_onehot[2'(w_base + w_sel)] = 1'b1;
    end

    assign win_any = |req;

endmodule : arb_pick4
`default_nettype wire

// File: rtl/encoder42.sv
`default_nettype none
// ============================================================================
//  Module      : encoder42
//  Description : 4-to-2 priority encoder, i4 highest. {o1,o0} = index of the
//                highest asserted input (i1 -> 0 ... i4 -> 3), 0 when none.
//  Ports       : i1..i4 inputs, o1/o0 encoded output bits.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder42 (
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    output logic o1,
    output logic o0
);

    assign o1 = i4 | i3;
    assign o0 = i4 | (i2 & ~i3);

    // i1 alone encodes to 2'd0, the same as no input, so it never drives an output.
    logic w_unused;
    assign w_unused = i1;

endmodule : encoder42
`default_nettype wire

// File: rtl/arbiter42_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter42_ctrl
//  Description : Four-requester arbiter/sequencer for one shared resource.
//                Registers a one-hot grant, holds it until the owner
//                releases (done or req drop), enforces a hold limit and
//                inserts one dead cycle between owners.
//  Ports       : clk, rst_n (async, active low), req[3:0], done
//                -> gnt[3:0], gnt_idx[1:0], busy, timeout
//  Revision    : 1.0  initial release
// ============================================================================
module arbiter42_ctrl
    import arbiter42_ctrl_pkg::*;
#(
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    // Last hold_cnt value of a grant; unused when MAX_HOLD == 0.
    localparam logic [HOLD_W-1:0] c_hold_last =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_gnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_last;
    logic              r_timeout;

    logic [3:0] w_win;
    logic       w_win_any;
    logic       w_owner_req;
    logic       w_rel_soft;
    logic       w_limit;

    arb_pick4 u_pick (
        .req        (req),
        .last       (r_last),
        .rr_en      (RR_EN != 0),
        .win_onehot (w_win),
        .win_any    (w_win_any)
    );

    encoder42 u_enc (
        .i1 (r_gnt[0]),
        .i2 (r_gnt[1]),
        .i3 (r_gnt[2]),
        .i4 (r_gnt[3]),
        .o1 (gnt_idx[1]),
        .o0 (gnt_idx[0])
    );

    assign w_owner_req = |(req & r_gnt);
    assign w_rel_soft  = done | ~w_owner_req;
    assign w_limit     = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_hold_cnt <= '0;
            r_last     <= 2'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_win_any) begin
                        r_gnt      <= w_win;
                        r_last     <= onehot_to_idx(w_win);
                        r_hold_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (w_rel_soft || w_limit) begin
                        r_gnt     <= '0;
                        r_state   <= ST_GAP;
                        // Flag only releases forced purely by the hold limit.
                        r_timeout <= w_limit && !w_rel_soft;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = |r_gnt;
    assign timeout = r_timeout;

endmodule : arbiter42_ctrl
`default_nettype wire

// File: tb/tb_arbiter42_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter42_ctrl
//  Description : Scoreboard bench for arbiter42_ctrl. A round-robin instance
//                (u_dut) and a fixed-priority instance (u_fix) share inputs.
//                Each completed grant (gnt value, length, timeout in the
//                following cycle, dead cycle present) is compared against a
//                queue of hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arbiter42_ctrl;

    typedef struct {
        logic [3:0] g;
        int         len;
        bit         to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt0, gnt1;
    logic [1:0] idx0, idx1;
    logic       busy0, busy1, to0, to1;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    arbiter42_ctrl #(.RR_EN(1), .MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt0), .gnt_idx(idx0), .busy(busy0), .timeout(to0)
    );

    arbiter42_ctrl #(.RR_EN(0), .MAX_HOLD(8), .HOLD_W(4)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(idx1), .busy(busy1), .timeout(to1)
    );

    task automatic chk(input bit ok, input string nm, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
        end
    endtask

    function automatic logic [1:0] ref_idx(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit onehot0(input logic [3:0] g);
        return (g & (g - 4'd1)) == 4'd0;
    endfunction

    task automatic push_both(input logic [3:0] g, input int len, input bit to);
        exp_t e;
        e.g = g; e.len = len; e.to = to;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic [3:0] prev_g[2];
    int         cnt[2];
    logic [3:0] m_g;
    logic [1:0] m_i;
    logic       m_b, m_t;
    exp_t       m_e;
    bit         m_have;

    initial begin
        prev_g[0] = '0; prev_g[1] = '0;
        cnt[0] = 0; cnt[1] = 0;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_g = (d == 0) ? gnt0  : gnt1;
            m_i = (d == 0) ? idx0  : idx1;
            m_b = (d == 0) ? busy0 : busy1;
            m_t = (d == 0) ? to0   : to1;
            if (!rst_n) begin
                prev_g[d] = '0;
                cnt[d]    = 0;
            end else begin
                if (!onehot0(m_g) || m_i != ref_idx(m_g) || m_b != (|m_g))
                    chk(1'b0, "invariant_gnt_idx_busy", {m_g, m_i, m_b}, {m_g, ref_idx(m_g), |m_g});
                if (prev_g[d] != 4'd0 && m_g != prev_g[d]) begin
                    m_have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
                    if (!m_have) begin
                        chk(1'b0, "unexpected_grant", prev_g[d], 0);
                    end else begin
                        chk(prev_g[d] == m_e.g, (d == 0) ? "rr_grant_value" : "fix_grant_value", prev_g[d], m_e.g);
                        chk(cnt[d] == m_e.len, (d == 0) ? "rr_grant_len" : "fix_grant_len", cnt[d], m_e.len);
                        chk(m_t == m_e.to, (d == 0) ? "rr_timeout" : "fix_timeout", m_t, m_e.to);
                        chk(m_g == 4'd0, "dead_cycle", m_g, 0);
                    end
                    cnt[d] = 0;
                end else if (m_t) begin
                    chk(1'b0, "stray_timeout", m_t, 0);
                end
                if (m_g != 4'd0) cnt[d] = (m_g == prev_g[d]) ? cnt[d] + 1 : 1;
                prev_g[d] = m_g;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (busy0) return;
            tick();
        end
        chk(1'b0, nm, 0, 1);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;

        // 1: reset held with all requests active
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(gnt0 == 4'd0 && idx0 == 2'd0 && !busy0 && !to0, "reset_state", {gnt0, idx0, busy0, to0}, 0);
        end

        // 3: round-robin rotation 3,2,1,0,3 (fixed instance stays on 3)
        push_both(4'b1000, 1, 1'b0);
        e.len = 1; e.to = 1'b0;
        e.g = 4'b0100; q0.push_back(e);
        e.g = 4'b0010; q0.push_back(e);
        e.g = 4'b0001; q0.push_back(e);
        e.g = 4'b1000; q0.push_back(e);
        for (int k = 0; k < 4; k++) q1.push_back(e);
        rst_n = 1'b1;
        tick();
        chk(gnt0 == 4'b1000, "first_grant_after_reset", gnt0, 4'b1000);
        for (int k = 0; k < 5; k++) begin
            wait_busy("rr_wait_grant");
            done = 1'b1;
            if (k == 4) req = 4'b0000;
            tick();
            done = 1'b0;
        end
        tick(); tick();

        // 2: req 0110 -> owner 2, done at edge 3 -> owner 1
        push_both(4'b0100, 3, 1'b0);
        push_both(4'b0010, 1, 1'b0);
        req = 4'b0110;
        tick();
        chk(gnt0 == 4'b0100 && idx0 == 2'd2, "latency_grant", {gnt0, idx0}, {4'b0100, 2'd2});
        tick(); tick();
        done = 1'b1; req = 4'b0010;
        tick();
        done = 1'b0;
        chk(gnt0 == 4'd0, "gap_after_done", gnt0, 0);
        tick();
        chk(gnt0 == 4'b0010 && idx0 == 2'd1, "second_owner", {gnt0, idx0}, {4'b0010, 2'd1});
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        tick(); tick();

        // 4: hold limit -> timeout, regrant; then done on the 8th cycle
        push_both(4'b0010, 8, 1'b1);
        push_both(4'b0010, 8, 1'b0);
        req = 4'b0010;
        wait_busy("timeout_wait_grant");
        repeat (8) tick();
        chk(to0 == 1'b1 && gnt0 == 4'd0, "timeout_pulse", {to0, gnt0}, {1'b1, 4'd0});
        tick();
        wait_busy("timeout_regrant");
        repeat (7) tick();
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        chk(to0 == 1'b0, "timeout_suppressed_by_done", to0, 0);
        tick(); tick();

        // 5: owner withdraws request; pending 0011 -> owner 1
        push_both(4'b0100, 2, 1'b0);
        push_both(4'b0010, 1, 1'b0);
        req = 4'b0100;
        wait_busy("withdraw_wait_grant");
        tick();
        req = 4'b0011;
        tick();
        chk(gnt0 == 4'd0 && to0 == 1'b0, "withdraw_release", {gnt0, to0}, 0);
        tick();
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        tick(); tick();

        // 6: asynchronous reset in the middle of a grant
        push_both(4'b0001, 1, 1'b0);
        req = 4'b0001;
        wait_busy("async_wait_grant");
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk(gnt0 == 4'd0 && !busy0 && gnt1 == 4'd0, "async_reset_clear", {gnt0, busy0}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk(gnt0 == 4'b0001 && idx0 == 2'd0, "grant_after_async_reset", gnt0, 4'b0001);
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        tick(); tick(); tick();

        chk(q0.size() == 0, "rr_queue_drained", q0.size(), 0);
        chk(q1.size() == 0, "fix_queue_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_arbiter42_ctrl
`default_nettype wire
